// File: rtl/fulladder_bist.sv
// Built-in self-test controller for a 1-bit full adder: sweeps all eight
// {a,b,cin} vectors, compares the returned sum/carry against the golden
// full-adder function and records per-vector pass/fail results.
module fulladder_bist #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       dut_s,
  input  logic       dut_cout,
  output logic       a,
  output logic       b,
  output logic       cin,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_mask,
  output logic [2:0] first_fail,
  output logic       fail_valid
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned VEC_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(7);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [VEC_W-1:0] vec, vec_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       stim, stim_n;
  logic             busy_n, done_n, fail_valid_n;
  logic [3:0]       err_count_n;
  logic [7:0]       fail_mask_n;
  logic [2:0]       first_fail_n;
  logic             exp_s, exp_cout, mismatch;

  assign {a, b, cin} = stim;
  assign pass        = done && (err_count == 4'd0);

  // Golden full-adder response for the vector currently presented.
  always_comb begin
    exp_s    = vec[2] ^ vec[1] ^ vec[0];
    exp_cout = (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]);
    mismatch = (dut_s != exp_s) || (dut_cout != exp_cout);
  end

  // State and result registers; reset discards any partial sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      vec        <= '0;
      cnt        <= '0;
      stim       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_count  <= '0;
      fail_mask  <= '0;
      first_fail <= '0;
      fail_valid <= 1'b0;
    end else begin
      state      <= state_n;
      vec        <= vec_n;
      cnt        <= cnt_n;
      stim       <= stim_n;
      busy       <= busy_n;
      done       <= done_n;
      err_count  <= err_count_n;
      fail_mask  <= fail_mask_n;
      first_fail <= first_fail_n;
      fail_valid <= fail_valid_n;
    end
  end

  // Sweep sequencing, response checking and result accumulation.
  always_comb begin
    state_n      = state;
    vec_n        = vec;
    cnt_n        = cnt;
    stim_n       = stim;
    busy_n       = busy;
    done_n       = done;
    err_count_n  = err_count;
    fail_mask_n  = fail_mask;
    first_fail_n = first_fail;
    fail_valid_n = fail_valid;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n      = DRIVE;
          vec_n        = '0;
          cnt_n        = '0;
          stim_n       = '0;
          busy_n       = 1'b1;
          done_n       = 1'b0;
          err_count_n  = '0;
          fail_mask_n  = '0;
          first_fail_n = '0;
          fail_valid_n = 1'b0;
        end
      end

      DRIVE: begin
        cnt_n = CNT_W'(cnt + 4'd1);
        if (cnt == CNT_LAST) begin
          if (mismatch) begin
            fail_mask_n = fail_mask | (8'd1 << vec);
            err_count_n = 4'(err_count + 4'd1);
            if (!fail_valid) begin
              first_fail_n = vec;
              fail_valid_n = 1'b1;
            end
          end
          cnt_n = '0;
          if (vec == VEC_LAST) begin
            state_n = DONE;
            vec_n   = '0;
            stim_n  = '0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            vec_n  = VEC_W'(vec + 3'd1);
            stim_n = VEC_W'(vec + 3'd1);
          end
        end
      end

      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        stim_n  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_fulladder_bist.sv
// Testbench for fulladder_bist: a behavioural adder with injectable faults,
// per-cycle and per-sweep expectations queued at stimulus time.
module tb_fulladder_bist;

  localparam int unsigned S = 2;
  localparam int unsigned SWEEP = 8 * S;

  logic       clk;
  logic       reset;
  logic       start;
  logic       dut_s;
  logic       dut_cout;
  logic       a, b, cin;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [7:0] fail_mask;
  logic [2:0] first_fail;
  logic       fail_valid;

  // 0: correct adder, 1: carry stuck at 0, 2: sum inverted
  int mode;
  int checks;
  int errors;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [2:0] abc;
  } cyc_t;

  typedef struct packed {
    logic [3:0] err;
    logic [7:0] mask;
    logic [2:0] first;
    logic       valid;
    logic       pass;
  } res_t;

  cyc_t cyc_q[$];
  res_t res_q[$];

  fulladder_bist #(.SETTLE_CYCLES(S)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dut_s      (dut_s),
    .dut_cout   (dut_cout),
    .a          (a),
    .b          (b),
    .cin        (cin),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .fail_mask  (fail_mask),
    .first_fail (first_fail),
    .fail_valid (fail_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder under test, built from an arithmetic sum with optional faults.
  always_comb begin
    logic [1:0] sum;
    sum      = 2'(a) + 2'(b) + 2'(cin);
    dut_s    = sum[0] ^ (mode == 2);
    dut_cout = (mode == 1) ? 1'b0 : sum[1];
  end

  // Expected sweep results for a given fault mode.
  function automatic res_t model_result(input int m);
    res_t r;
    r = '0;
    for (int v = 0; v < 8; v++) begin
      int  total;
      logic gs, gc, ds, dc;
      total = ((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1);
      gs = (total % 2) == 1;
      gc = total >= 2;
      ds = gs ^ (m == 2);
      dc = (m == 1) ? 1'b0 : gc;
      if (ds != gs || dc != gc) begin
        r.mask[v] = 1'b1;
        r.err     = r.err + 4'd1;
        if (!r.valid) begin
          r.first = 3'(v);
          r.valid = 1'b1;
        end
      end
    end
    r.pass = (r.err == 4'd0);
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    mode  = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a, b, cin, busy, done, pass, err_count, fail_mask, first_fail, fail_valid} !== 22'd0) begin
      errors++;
      $display("FAIL reset_state: got a/b/cin=%b%b%b busy=%b done=%b pass=%b err=%0d mask=%h first=%0d valid=%b, want all zero",
               a, b, cin, busy, done, pass, err_count, fail_mask, first_fail, fail_valid);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL idle_hold: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  // Runs one full sweep with the given fault mode; optionally re-pulses start at E5.
  task automatic run_sweep(input string name, input int m, input bit repulse);
    cyc_t ec;
    res_t er;
    mode  = m;
    start = 1'b1;
    for (int k = 0; k <= int'(SWEEP); k++) begin
      ec.busy = (k < int'(SWEEP));
      ec.done = (k == int'(SWEEP));
      ec.abc  = (k < int'(SWEEP)) ? 3'(k / int'(S)) : 3'd0;
      cyc_q.push_back(ec);
    end
    res_q.push_back(model_result(m));
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if ({done, err_count, fail_mask, fail_valid} !== 14'd0) begin
      errors++;
      $display("FAIL %s_clear_on_start: done=%b err=%0d mask=%h valid=%b, want 0", name, done, err_count, fail_mask, fail_valid);
    end
    for (int k = 0; k <= int'(SWEEP); k++) begin
      if (k > 0) begin
        start = repulse && (k == 5);
        @(posedge clk);
        #1;
      end
      ec = cyc_q.pop_front();
      checks++;
      if ({busy, done, a, b, cin} !== {ec.busy, ec.done, ec.abc}) begin
        errors++;
        $display("FAIL %s_cycle%0d: busy=%b done=%b abc=%b%b%b, want busy=%b done=%b abc=%b",
                 name, k, busy, done, a, b, cin, ec.busy, ec.done, ec.abc);
      end
    end
    start = 1'b0;
    er = res_q.pop_front();
    checks++;
    if (err_count !== er.err) begin
      errors++;
      $display("FAIL %s_err_count: got %0d want %0d", name, err_count, er.err);
    end
    checks++;
    if (fail_mask !== er.mask) begin
      errors++;
      $display("FAIL %s_fail_mask: got %h want %h", name, fail_mask, er.mask);
    end
    checks++;
    if (fail_valid !== er.valid) begin
      errors++;
      $display("FAIL %s_fail_valid: got %b want %b", name, fail_valid, er.valid);
    end
    if (er.valid) begin
      checks++;
      if (first_fail !== er.first) begin
        errors++;
        $display("FAIL %s_first_fail: got %0d want %0d", name, first_fail, er.first);
      end
    end
    checks++;
    if (pass !== er.pass) begin
      errors++;
      $display("FAIL %s_pass: got %b want %b", name, pass, er.pass);
    end
  endtask

  task automatic test_good_sweep();
    run_sweep("good", 0, 1'b0);
  endtask

  task automatic test_cout_stuck();
    run_sweep("cout_stuck", 1, 1'b0);
  endtask

  task automatic test_sum_inverted();
    run_sweep("sum_inv", 2, 1'b0);
  endtask

  task automatic test_start_ignored();
    run_sweep("repulse", 1, 1'b1);
  endtask

  task automatic test_reset_mid_sweep();
    mode  = 1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    checks++;
    if ({a, b, cin, busy, done, pass, err_count, fail_mask, first_fail, fail_valid} !== 22'd0) begin
      errors++;
      $display("FAIL reset_mid: got a/b/cin=%b%b%b busy=%b done=%b err=%0d mask=%h first=%0d valid=%b, want all zero",
               a, b, cin, busy, done, err_count, fail_mask, first_fail, fail_valid);
    end
    @(posedge clk);
    #1;
    run_sweep("after_reset", 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_sweep("b2b_fail", 1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, err_count, fail_mask} !== {1'b0, 1'b1, 4'd4, 8'hE8}) begin
      errors++;
      $display("FAIL done_hold: busy=%b done=%b err=%0d mask=%h, want 0 1 4 e8", busy, done, err_count, fail_mask);
    end
    run_sweep("b2b_good", 0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    start  = 1'b0;
    mode   = 0;
    test_reset();
    test_good_sweep();
    test_cout_stuck();
    test_sum_inverted();
    test_start_ignored();
    test_reset_mid_sweep();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fulladder_bist.md
# fulladder_bist

Built-in self-test controller for the lab's 1-bit full adder: on command it sweeps all 8 `{a,b,cin}` input vectors into an external full-adder instance and checks the returned `s`/`cout` against the golden full-adder function. It accumulates a per-vector pass/fail result. It sits beside the adder on the board-level top, so a synthesized adder can be self-checked in hardware with results shown on LEDs.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling the DUT response; legal range 1..15.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a sweep; honoured in IDLE or DONE only.
- `dut_s`  in  1  sum returned by the adder under test.
- `dut_cout`  in  1  carry returned by the adder under test.
- `a`, `b`, `cin`  out  1 each  stimulus to the adder under test; registered.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  high from sweep completion until the next accepted `start` or `reset`.
- `pass`  out  1  `done && err_count==0`.
- `err_count`  out  4  number of failing vectors, 0..8.
- `fail_mask`  out  8  bit *i* set if vector index *i* failed.
- `first_fail`  out  3  index of the lowest-numbered failing vector; valid only when `fail_valid` is high.
- `fail_valid`  out  1  at least one failure recorded this sweep.

## Operation
- Vector index `vec[2:0]` maps to `{a,b,cin}`: `a=vec[2]`, `b=vec[1]`, `cin=vec[0]`. Vectors are applied in order 0→7.
- Expected response: `s = a^b^cin`; `cout = ab | a·cin | b·cin`. A vector fails if either `dut_s` or `dut_cout` mismatches.
- States:
  - **IDLE:** outputs at reset values. `start` → DRIVE, with `vec=0`, settle counter `cnt=0`, and all result registers cleared.
  - **DRIVE:** `busy=1`; `a/b/cin` driven from `vec`. `cnt` increments each cycle.
    - When `cnt==SETTLE_CYCLES-1`, sample `dut_s`/`dut_cout` on that edge and compare.
    - On a mismatch: set `fail_mask[vec]` and increment `err_count`. If `fail_valid==0`, load `first_fail=vec` and set `fail_valid`.
    - Same edge, if `vec==7` → DONE with `vec=0`; otherwise `vec++` and `cnt=0`.
  - **DONE:** `done=1`; results hold stable; `a/b/cin=0`. `start` → DRIVE, clearing results exactly as from IDLE.
- `start` while in DRIVE is ignored; the sweep continues unaffected.
- `err_count` saturates naturally at 8. The 4-bit width makes overflow impossible.

## Timing
- Reset: state IDLE; `a=b=cin=0`, `busy=0`, `done=0`, `pass=0`, `err_count=0`, `fail_mask=8'h00`, `first_fail=0`, `fail_valid=0`, `vec=0`, `cnt=0`.
- Reset asserted mid-sweep forces all of the above on the next edge. Partial results are discarded.
- Reset has priority over `start` on the same edge.
- With `start` sampled at edge E0:
  - `busy` is high from E0 to E(8·SETTLE_CYCLES).
  - Vector *i* is presented from edge E(i·SETTLE_CYCLES) and sampled at edge E((i+1)·SETTLE_CYCLES).
  - `done` rises at E(8·SETTLE_CYCLES), in the same cycle that `busy` falls. `busy` and `done` are never both high.
- Result registers update on the sampling edge of each vector. `pass` is combinational from registered `done` and `err_count`.
- The DUT is combinational, so its path must settle within `SETTLE_CYCLES-1` cycles plus one clock period.

## Test plan
- Correct adder model, `SETTLE_CYCLES=2`, `start` pulse at E0:
  - `busy` is high for 16 cycles; `done=1` from E16.
  - `err_count=0`, `fail_mask=8'h00`, `fail_valid=0`, `pass=1`.
  - `{a,b,cin}` steps 000→111, each value held 2 cycles.
- `dut_cout` stuck at 0, correct sum: `err_count=4`, `fail_mask=8'hE8` (vectors 3,5,6,7), `first_fail=3`, `fail_valid=1`, `pass=0`.
- `dut_s` inverted, correct carry: `err_count=8`, `fail_mask=8'hFF`, `first_fail=0`, `pass=0`.
- `start` re-pulsed at E5 during a sweep: no restart; `done` still rises at E16 with the same results as the undisturbed run.
- `reset` asserted at E7 of a failing sweep: the next cycle shows all outputs at reset values with `busy=0`. A later `start` produces a full, correct sweep.
- After a DONE with `err_count=4`, swap to the correct model and pulse `start`:
  - Results are cleared on the accepted edge, so `done` drops.
  - The new sweep ends with `pass=1` and `fail_mask=8'h00`.
